// File: rtl/u110_pci_pkg.sv
// u110_pci_pkg: PCI command codes, target FSM state encoding and default timing constants
package u110_pci_pkg;

    localparam logic [3:0] CMD_MEM_READ       = 4'b0110;
    localparam logic [3:0] CMD_MEM_READ_MULT  = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE  = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE      = 4'b0111;
    localparam logic [3:0] CMD_MEM_WRITE_INV  = 4'b1111;

    localparam int RETRY_CLKS_DEF = 16;
    localparam int CNT_W          = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_LOCAL,
        ST_DATA,
        ST_RETRY,
        ST_BACKOFF
    } tgt_state_e;

    function automatic logic is_mem_read(input logic [3:0] cmd);
        return cmd inside {CMD_MEM_READ, CMD_MEM_READ_MULT, CMD_MEM_READ_LINE};
    endfunction

    function automatic logic is_mem_write(input logic [3:0] cmd);
        return cmd inside {CMD_MEM_WRITE, CMD_MEM_WRITE_INV};
    endfunction

endpackage

// File: rtl/u110_pci_parity.sv
// u110_pci_parity: even parity over the 32 AD bits and 4 C/BE# bits of a data phase
module u110_pci_parity (
    input  logic [35:0] bits_in,
    output logic        par_out
);

    assign par_out = ^bits_in;

endmodule

// File: rtl/u110_pci_target.sv
// u110_pci_target: single-data-phase PCI memory target bridging into the local request/acknowledge port; PAR generation under U110_PCI_PAR_EN
module u110_pci_target
    import u110_pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          WIN_BITS   = 24,
    parameter int          RETRY_CLKS = RETRY_CLKS_DEF
) (
    input  logic        CLK33,
    input  logic        RESETn,
    input  logic [31:0] AD_IN,
    input  logic [3:0]  CBEn,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    output logic [31:0] AD_OUT,
    output logic        AD_OE,
    output logic        DEVSELn_OUT,
    output logic        TRDYn_OUT,
    output logic        STOPn_OUT,
    output logic        TGT_OE,
    output logic        PAR_OUT,
    output logic        PAR_OE,
    output logic        LREQ,
    output logic        LWRITE,
    output logic [31:0] LADDR,
    output logic [3:0]  LBEn,
    output logic [31:0] LWDATA,
    input  logic [31:0] LRDATA,
    input  logic        LACK,
    output logic        LABORT
);

    // The counter holds the clock index since the address phase; reaching
    // RETRY_CLKS at the next edge forces the Retry.
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RETRY_CLKS - 1);

    tgt_state_e        state_q, state_d;
    logic              frame_q, frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lreq_q, lreq_d;
    logic              lwrite_q, lwrite_d;
    logic [31:0]       laddr_q, laddr_d;
    logic [3:0]        lben_q, lben_d;
    logic [31:0]       lwdata_q, lwdata_d;
    logic [31:0]       ad_out_q, ad_out_d;
    logic              labort_q, labort_d;
    logic              claim;
    logic              lack_hit;
    logic              timeout;

    assign claim = (state_q == ST_IDLE) && !FRAMEn && frame_q &&
                   (is_mem_read(CBEn) || is_mem_write(CBEn)) &&
                   (AD_IN[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign lack_hit = lreq_q && LACK;
    assign timeout  = cnt_q >= TIMEOUT_CNT;

    // FSM state register
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a LACK in the timeout clock still completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = claim ? ST_DECODE : ST_IDLE;
            ST_DECODE:     state_d = ST_WAIT_LOCAL;
            ST_WAIT_LOCAL: state_d = lack_hit ? ST_DATA : (timeout ? ST_RETRY : ST_WAIT_LOCAL);
            ST_DATA:       state_d = ST_BACKOFF;
            ST_RETRY:      state_d = FRAMEn ? ST_BACKOFF : ST_RETRY;
            ST_BACKOFF:    state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Datapath and local-port registers
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            frame_q  <= 1'b1;
            cnt_q    <= '0;
            lreq_q   <= 1'b0;
            lwrite_q <= 1'b0;
            laddr_q  <= '0;
            lben_q   <= '0;
            lwdata_q <= '0;
            ad_out_q <= '0;
            labort_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            lreq_q   <= lreq_d;
            lwrite_q <= lwrite_d;
            laddr_q  <= laddr_d;
            lben_q   <= lben_d;
            lwdata_q <= lwdata_d;
            ad_out_q <= ad_out_d;
            labort_q <= labort_d;
        end
    end

    // Address latch, local request handshake, read-data capture and saturating counter
    always_comb begin
        frame_d  = FRAMEn;
        cnt_d    = (state_d == ST_IDLE) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
        lreq_d   = lreq_q;
        lwrite_d = lwrite_q;
        laddr_d  = laddr_q;
        lben_d   = lben_q;
        lwdata_d = lwdata_q;
        ad_out_d = ad_out_q;
        labort_d = 1'b0;
        if (claim) begin
            lwrite_d = is_mem_write(CBEn);
            laddr_d  = {AD_IN[31:2], 2'b00};
        end
        if (state_q == ST_WAIT_LOCAL) begin
            if (lack_hit) begin
                lreq_d   = 1'b0;
                ad_out_d = lwrite_q ? ad_out_q : LRDATA;
            end else if (timeout) begin
                lreq_d   = 1'b0;
                labort_d = lreq_q;
            end else if (!lreq_q && !IRDYn) begin
                lreq_d   = 1'b1;
                lben_d   = CBEn;
                lwdata_d = lwrite_q ? AD_IN : lwdata_q;
            end
        end
    end

    // Pad drive values decoded from the FSM state; STOP# in the data phase follows FRAME#
    always_comb begin
        TGT_OE      = state_q inside {ST_WAIT_LOCAL, ST_DATA, ST_RETRY, ST_BACKOFF};
        DEVSELn_OUT = !(state_q inside {ST_WAIT_LOCAL, ST_DATA, ST_RETRY});
        TRDYn_OUT   = state_q != ST_DATA;
        STOPn_OUT   = !((state_q == ST_DATA && !FRAMEn) || state_q == ST_RETRY);
        AD_OE       = TGT_OE && !lwrite_q;
    end

    assign AD_OUT = ad_out_q;
    assign LREQ   = lreq_q;
    assign LWRITE = lwrite_q;
    assign LADDR  = laddr_q;
    assign LBEn   = lben_q;
    assign LWDATA = lwdata_q;
    assign LABORT = labort_q;

`ifdef U110_PCI_PAR_EN
    logic par_bit;
    logic par_oe_q, par_oe_d;

    u110_pci_parity u_parity (
        .bits_in ({ad_out_q, lben_q}),
        .par_out (par_bit)
    );

    // PAR is driven for the single clock following a read TRDY#
    always_comb begin
        par_oe_d = (state_q == ST_DATA) && !lwrite_q;
    end

    // Parity output-enable register
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            par_oe_q <= 1'b0;
        end else begin
            par_oe_q <= par_oe_d;
        end
    end

    assign PAR_OE  = par_oe_q;
    assign PAR_OUT = par_oe_q & par_bit;
`else
    assign PAR_OE  = 1'b0;
    assign PAR_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_u110_pci_target.sv
// tb_u110_pci_target: table-driven and randomized transactions against a timeline model of the PCI target
module tb_u110_pci_target;

    logic        CLK33 = 1'b0;
    logic        RESETn = 1'b0;
    logic [31:0] AD_IN = '0;
    logic [3:0]  CBEn = '1;
    logic        FRAMEn = 1'b1;
    logic        IRDYn = 1'b1;
    logic [31:0] AD_OUT;
    logic        AD_OE;
    logic        DEVSELn_OUT;
    logic        TRDYn_OUT;
    logic        STOPn_OUT;
    logic        TGT_OE;
    logic        PAR_OUT;
    logic        PAR_OE;
    logic        LREQ;
    logic        LWRITE;
    logic [31:0] LADDR;
    logic [3:0]  LBEn;
    logic [31:0] LWDATA;
    logic [31:0] LRDATA = '0;
    logic        LACK = 1'b0;
    logic        LABORT;

`ifdef U110_PCI_PAR_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    always #5 CLK33 = ~CLK33;

    u110_pci_target u_dut (
        .CLK33       (CLK33),
        .RESETn      (RESETn),
        .AD_IN       (AD_IN),
        .CBEn        (CBEn),
        .FRAMEn      (FRAMEn),
        .IRDYn       (IRDYn),
        .AD_OUT      (AD_OUT),
        .AD_OE       (AD_OE),
        .DEVSELn_OUT (DEVSELn_OUT),
        .TRDYn_OUT   (TRDYn_OUT),
        .STOPn_OUT   (STOPn_OUT),
        .TGT_OE      (TGT_OE),
        .PAR_OUT     (PAR_OUT),
        .PAR_OE      (PAR_OE),
        .LREQ        (LREQ),
        .LWRITE      (LWRITE),
        .LADDR       (LADDR),
        .LBEn        (LBEn),
        .LWDATA      (LWDATA),
        .LRDATA      (LRDATA),
        .LACK        (LACK),
        .LABORT      (LABORT)
    );

    // d: clocks from LREQ to LACK (-1 = never); hold: FRAME# kept low until TRDY#/STOP#;
    // refire: new FRAME# falling edge in BACKOFF; rst_at: clock of a mid-transaction reset (-1 = none);
    // exp_t: clock of TRDY# relative to the address clock (0 = transaction ends in Retry)
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;
        bit          hold;
        bit          refire;
        int          rst_at;
        bit          exp_claim;
        int          exp_t;
    } vec_t;

    localparam logic [8:0] RELEASED = 9'b111_000_000;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tab[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_wr(input logic [3:0] c);
        return c inside {4'b0111, 4'b1111};
    endfunction

    function automatic bit model_claim(input logic [31:0] a, input logic [3:0] c);
        return (a[31:24] == 8'h40) && (c inside {4'b0110, 4'b1100, 4'b1110, 4'b0111, 4'b1111});
    endfunction

    // LREQ rises at address clock + 3; the cycle completes the clock after LACK
    // when LACK arrives no later than clock 15, otherwise Retry at clock 16.
    function automatic int model_t(input bit claim, input int d);
        return (claim && d >= 0 && 3 + d <= 15) ? 4 + d : 0;
    endfunction

    // Expected {DEVSEL#, TRDY#, STOP#, TGT_OE, AD_OE, LREQ, LABORT, PAR_OE, PAR_OUT} at clock k
    function automatic logic [8:0] exp_vec(input int k, input vec_t v);
        bit rd, devsel, trdy, stop, tgt, adoe, lreq, labort, poe, pout;
        int e, b;
        rd = !is_wr(v.cmd);
        e  = v.hold ? 17 : 16;
        b  = (v.exp_t != 0) ? v.exp_t + 1 : e + 1;
        if (!v.exp_claim || (v.rst_at >= 0 && k >= v.rst_at)) return RELEASED;
        tgt    = k >= 2 && k <= b;
        devsel = k >= 2 && k < b;
        adoe   = rd && tgt;
        trdy   = v.exp_t != 0 && k == v.exp_t;
        stop   = (v.exp_t != 0) ? (k == v.exp_t && v.hold) : (k >= 16 && k <= e);
        lreq   = k >= 3 && k < ((v.exp_t != 0) ? v.exp_t : 16);
        labort = v.exp_t == 0 && k == 16;
        poe    = PAR_EN && rd && v.exp_t != 0 && k == v.exp_t + 1;
        pout   = poe && (^{v.rdata, v.be});
        return {!devsel, !trdy, !stop, tgt, adoe, lreq, labort, poe, pout};
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        bit         ended;
        bit         rst_now;
        bit         wr;
        bit         addr_phase;
        int         ls;
        int         rb;
        logic [8:0] got;
        ended = 1'b0;
        ls    = -1;
        wr    = is_wr(v.cmd);
        rb    = v.exp_t + 1;
        for (int k = -1; k < 22; k++) begin
            rst_now    = v.rst_at >= 0 && k >= v.rst_at;
            addr_phase = k == 0 || (v.refire && v.exp_t != 0 && k == rb);
            @(posedge CLK33);
            #1;
            if (LREQ && ls < 0) ls = k;
            FRAMEn = rst_now || !(addr_phase || (v.hold && k > 0 && !ended));
            IRDYn  = rst_now || !(k >= 1 && !ended);
            AD_IN  = addr_phase ? v.addr : (wr ? v.wdata : $urandom());
            CBEn   = addr_phase ? v.cmd : v.be;
            LACK   = !rst_now && v.d >= 0 && LREQ && ls >= 0 && k == ls + v.d;
            LRDATA = LACK ? v.rdata : $urandom();
            RESETn = !(v.rst_at >= 0 && k == v.rst_at);
            #1;
            got = {DEVSELn_OUT, TRDYn_OUT, STOPn_OUT, TGT_OE, AD_OE, LREQ, LABORT, PAR_OE, PAR_OUT};
            chk($sformatf("%s ctl k=%0d", tag, k), 128'(got), 128'(exp_vec(k, v)));
            if (v.rst_at >= 0 && k == v.rst_at)
                chk($sformatf("%s reset data", tag), 128'({LADDR, LWDATA, AD_OUT, LBEn, LWRITE}), 128'(0));
            if (v.exp_claim && k == 3 && !(v.rst_at >= 0 && v.rst_at <= 3))
                chk($sformatf("%s lreq fields", tag),
                    128'({LADDR, LBEn, LWRITE, wr ? LWDATA : 32'h0}),
                    128'({v.addr[31:2], 2'b00, v.be, wr, wr ? v.wdata : 32'h0}));
            if (v.exp_claim && !wr && v.exp_t != 0 && k == v.exp_t)
                chk($sformatf("%s rdata", tag), 128'(AD_OUT), 128'(v.rdata));
            if (!TRDYn_OUT || !STOPn_OUT) ended = 1'b1;
        end
    endtask

    initial begin
        vec_t        v;
        logic [31:0] rnd;
        tab[0]  = '{32'h4000_1000, 4'b0111, 4'b0101, 32'hCAFE_0001, 32'h0,         2,  1'b1, 1'b0, -1, 1'b1, 6};
        tab[1]  = '{32'h40FF_FFFC, 4'b0110, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0,  1'b0, 1'b0, -1, 1'b1, 4};
        tab[2]  = '{32'h4000_0020, 4'b0110, 4'b1100, 32'h0,         32'h1111_2222, -1, 1'b1, 1'b0, -1, 1'b1, 0};
        tab[3]  = '{32'h4012_3450, 4'b1100, 4'b0011, 32'h0,         32'h1357_9BDF, 12, 1'b1, 1'b0, -1, 1'b1, 16};
        tab[4]  = '{32'h4000_0400, 4'b1111, 4'b0000, 32'hA5A5_5A5A, 32'h0,         13, 1'b0, 1'b0, -1, 1'b1, 0};
        tab[5]  = '{32'h5000_0000, 4'b0110, 4'b0000, 32'h0,         32'h0,         0,  1'b0, 1'b0, -1, 1'b0, 0};
        tab[6]  = '{32'h4000_0000, 4'b0010, 4'b0000, 32'h0,         32'h0,         0,  1'b1, 1'b0, -1, 1'b0, 0};
        tab[7]  = '{32'h40AB_CDE7, 4'b1110, 4'b0000, 32'h0,         32'h0000_0001, 1,  1'b0, 1'b0, -1, 1'b1, 5};
        tab[8]  = '{32'h4000_0008, 4'b0111, 4'b1110, 32'h0BAD_F00D, 32'h0,         0,  1'b0, 1'b1, -1, 1'b1, 4};
        tab[9]  = '{32'h4000_0100, 4'b0110, 4'b0000, 32'h0,         32'h0,         -1, 1'b1, 1'b0, 6,  1'b1, 0};
        tab[10] = '{32'h3FFF_FFFC, 4'b0111, 4'b0000, 32'h0,         32'h0,         0,  1'b0, 1'b0, -1, 1'b0, 0};
        tab[11] = '{32'h4100_0000, 4'b1111, 4'b0000, 32'h0,         32'h0,         0,  1'b1, 1'b0, -1, 1'b0, 0};

        repeat (3) @(posedge CLK33);
        #2;
        chk("reset ctl", 128'({DEVSELn_OUT, TRDYn_OUT, STOPn_OUT, TGT_OE, AD_OE, LREQ, LABORT, PAR_OE, PAR_OUT}),
            128'(RELEASED));
        chk("reset data", 128'({LADDR, LWDATA, AD_OUT, LBEn, LWRITE}), 128'(0));
        @(posedge CLK33);
        #1;
        RESETn = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(tab[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rnd     = $urandom();
            v.addr  = ($urandom_range(0, 9) < 6) ? {8'h40, rnd[23:0]} : rnd;
            rnd     = $urandom();
            case ($urandom_range(0, 8))
                0: v.cmd = 4'b0110;
                1: v.cmd = 4'b1100;
                2: v.cmd = 4'b1110;
                3: v.cmd = 4'b0111;
                4: v.cmd = 4'b1111;
                5: v.cmd = 4'b0010;
                6: v.cmd = 4'b0011;
                7: v.cmd = 4'b1010;
                default: v.cmd = 4'b0000;
            endcase
            v.be        = rnd[3:0];
            v.wdata     = $urandom();
            v.rdata     = $urandom();
            v.d         = int'($urandom_range(0, 14)) - 1;
            v.hold      = rnd[4];
            v.rst_at    = -1;
            v.exp_claim = model_claim(v.addr, v.cmd);
            v.exp_t     = model_t(v.exp_claim, v.d);
            v.refire    = v.exp_claim && v.exp_t != 0 && rnd[5];
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
